par_circ_buffer: RTL
====================

PAR_CIRC_BUFFER -- requirements
Module: par_circ_buffer

Interface
REQ-001 The block SHALL have parameter SIZE, default 16, meaning element width in bits.
REQ-002 The block SHALL have parameter MEM_SIZE, default 16, meaning storage depth in elements; it is a power of two, at least 2.
REQ-003 The block SHALL have parameter PAR_WRITE, default 4, meaning elements accepted per write transfer; 1..MEM_SIZE.
REQ-004 The block SHALL have parameter PAR_READ, default 2, meaning elements delivered per read transfer; 1..MEM_SIZE.
REQ-005 The block SHALL have parameter ADDRES_SIZE, default $clog2(MEM_SIZE), meaning pointer width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous clear of buffer state.
REQ-009 The block SHALL have port wvalid, input, 1 bit: din holds a write transfer.
REQ-010 The block SHALL have port wready, output, 1 bit: the buffer can accept a write transfer.
REQ-011 The block SHALL have port din, input, SIZE*PAR_WRITE bits: lane k is din[k*SIZE +: SIZE].
REQ-012 The block SHALL have port rvalid, output, 1 bit: dout holds a read transfer.
REQ-013 The block SHALL have port rready, input, 1 bit: the consumer takes dout.
REQ-014 The block SHALL have port dout, output, SIZE*PAR_READ bits: lane i is dout[i*SIZE +: SIZE].
REQ-015 The block SHALL have port level, output, ADDRES_SIZE+1 bits: the count of stored elements.

Function
REQ-016 Storage SHALL be a circular array of MEM_SIZE elements, with a write pointer wptr, a read pointer rptr and a count register; all pointer arithmetic SHALL be modulo MEM_SIZE.
REQ-017 wready SHALL equal (MEM_SIZE - level) >= PAR_WRITE, evaluated on registered level only; a pop in the same cycle does not raise it.
REQ-018 rvalid SHALL equal level >= PAR_READ; a push in the same cycle does not raise it.
REQ-019 Push occurs when wvalid and wready are both high: din lane k SHALL be written to element (wptr+k) mod MEM_SIZE, and wptr SHALL advance by PAR_WRITE.
REQ-020 Pop occurs when rvalid and rready are both high: rptr SHALL advance by PAR_READ.
REQ-021 dout lane i SHALL be element (rptr+i) mod MEM_SIZE, combinational from storage (first-word fall-through).
REQ-022 dout SHALL be all-zero whenever rvalid is low.
REQ-023 Latency: data pushed at edge N SHALL be visible on dout after edge N when it is at the head.
REQ-024 level SHALL update at each edge by +PAR_WRITE on push, -PAR_READ on pop, and PAR_WRITE-PAR_READ on simultaneous push and pop; it never exceeds MEM_SIZE or goes below 0.
REQ-025 A write attempted with wready low SHALL be dropped with no state change; a pop attempted with rvalid low SHALL be ignored.
REQ-026 Wrap-around: a transfer that straddles index MEM_SIZE-1 SHALL continue at index 0 with element order preserved.
REQ-027 flush high at an edge SHALL zero wptr, rptr and level, and SHALL override any push or pop in the same cycle; storage contents are left unchanged.

Reset
REQ-028 While rst_n is low, wptr, rptr and level SHALL be 0 immediately, without waiting for a clock edge; therefore wready=1 (given PAR_WRITE<=MEM_SIZE), rvalid=0 and dout=0.
REQ-029 Storage contents SHALL NOT be reset.
REQ-030 Reset asserted mid-transfer SHALL discard that transfer.
REQ-031 Operation SHALL resume on the first edge after rst_n rises.

Configuration
REQ-032 When macro PAR_CIRC_BUFFER_STATUS_EN is defined, the block SHALL add sticky 1-bit outputs ovf_err and udf_err.
REQ-033 ovf_err SHALL be set by wvalid with wready low.
REQ-034 udf_err SHALL be set by rready with rvalid low.
REQ-035 ovf_err and udf_err SHALL be cleared only by reset or flush.
REQ-036 When PAR_CIRC_BUFFER_STATUS_EN is undefined, these ports and their logic SHALL be absent; all other behaviour is identical.

Verification (default parameters)
REQ-037 Scenario: after reset, push din lanes 0..3 = 0x0001..0x0004 -> next cycle level=4, rvalid=1, dout={0x0002,0x0001}.
REQ-038 Scenario: four pushes -> level=16, wready=0; a fifth wvalid is dropped, level stays 16, and ovf_err=1 when enabled.
REQ-039 Scenario: from full, pop twice -> level=12, wready=1; push 0x000A..0x000D -> writes indices 0..3; draining returns all 16 elements in push order.
REQ-040 Scenario: at level 4, push and pop in the same cycle -> level=6 and the head advances by 2.
REQ-041 Scenario: at level 8, rst_n driven low between edges -> immediately level=0, rvalid=0, dout=0, wready=1.
REQ-042 Scenario: at level 6, flush with wvalid and rready high -> next cycle level=0, no write performed, and error flags cleared.

Source files
------------

// File: rtl/par_circ_buffer.sv
// Circular buffer that takes PAR_WRITE elements per write and gives PAR_READ elements per read.
// Optional sticky ovf_err/udf_err outputs are enabled by defining PAR_CIRC_BUFFER_STATUS_EN.
module par_circ_buffer #(
    parameter int SIZE        = 16,
    parameter int MEM_SIZE    = 16,
    parameter int PAR_WRITE   = 4,
    parameter int PAR_READ    = 2,
    parameter int ADDRES_SIZE = $clog2(MEM_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [SIZE*PAR_WRITE-1:0] din,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [SIZE*PAR_READ-1:0]  dout,
    output logic [ADDRES_SIZE:0]      level
`ifdef PAR_CIRC_BUFFER_STATUS_EN
    ,
    output logic                      ovf_err,
    output logic                      udf_err
`endif
);

    localparam int LW = ADDRES_SIZE + 1;
    localparam logic [ADDRES_SIZE-1:0] PW_A     = ADDRES_SIZE'(PAR_WRITE);
    localparam logic [ADDRES_SIZE-1:0] PR_A     = ADDRES_SIZE'(PAR_READ);
    localparam logic [LW-1:0]          PW_L     = LW'(PAR_WRITE);
    localparam logic [LW-1:0]          PR_L     = LW'(PAR_READ);
    localparam logic [LW-1:0]          WR_LIMIT = LW'(MEM_SIZE - PAR_WRITE);

    logic [SIZE-1:0]        mem [MEM_SIZE];
    logic [ADDRES_SIZE-1:0] wptr;
    logic [ADDRES_SIZE-1:0] rptr;
    logic                   push;
    logic                   pop;

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; ready/valid depend only on the registered level, never on the other side.
    assign wready = (level <= WR_LIMIT);
    assign rvalid = (level >= PR_L);
    assign push   = wvalid && wready && !flush;
    assign pop    = rready && rvalid && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + PW_A;
            if (pop)  rptr <= rptr + PR_A;
            level <= level + (push ? PW_L : '0) - (pop ? PR_L : '0);
        end
    end

    // Storage is never reset; the rst_n term drops a write seen while reset is held.
    always_ff @(posedge clk) begin
        if (push && rst_n) begin
            for (int k = 0; k < PAR_WRITE; k++) begin
                mem[wptr + ADDRES_SIZE'(k)] <= din[k*SIZE +: SIZE];
            end
        end
    end

    always_comb begin
        dout = '0;
        if (rvalid) begin
            for (int i = 0; i < PAR_READ; i++) begin
                dout[i*SIZE +: SIZE] = mem[rptr + ADDRES_SIZE'(i)];
            end
        end
    end

`ifdef PAR_CIRC_BUFFER_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else if (flush) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wvalid && !wready) ovf_err <= 1'b1;
            if (rready && !rvalid) udf_err <= 1'b1;
        end
    end
`endif

endmodule
